// File: rtl/vec_issue_sequencer.sv
// Vector issue sequencer: splits a VL-element vector op into LANES-wide beats,
// pulses the register-file commit, and raises stalls for busy/RAW hazards.
module vec_issue_sequencer #(
    parameter int NUM_ELEMS = 16,
    parameter int LANES     = 4,
    parameter int ADDR_W    = 4,
    parameter int IDX_W     = $clog2(NUM_ELEMS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IssueD,
    input  logic [ADDR_W-1:0] WA3D,
    input  logic [IDX_W:0]    VLD,
    input  logic [ADDR_W-1:0] RA1D,
    input  logic [ADDR_W-1:0] RA2D,
    input  logic              Abort,
    output logic              Busy,
    output logic              StallVec,
    output logic              BeatValid,
    output logic [IDX_W-1:0]  ElemIdx,
    output logic [LANES-1:0]  LaneEn,
    output logic [ADDR_W-1:0] WA3V,
    output logic              RegWriteV,
    output logic              Done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        COMMIT = 2'd2
    } seqState_t;

    localparam logic [IDX_W:0]   MAX_VL    = (IDX_W+1)'(NUM_ELEMS);
    localparam logic [IDX_W:0]   LANES_EXT = (IDX_W+1)'(LANES);
    localparam logic [IDX_W-1:0] LANES_IDX = IDX_W'(LANES);

    seqState_t      state, stateNext;
    logic [IDX_W:0] vl;
    logic [IDX_W:0] vlClamped;
    logic [IDX_W:0] elemIdxExt;
    logic           accept;
    logic           lastBeat;

    assign vlClamped  = (VLD > MAX_VL) ? MAX_VL : VLD;
    assign elemIdxExt = {1'b0, ElemIdx};
    assign accept     = (state == IDLE) && IssueD && !Abort;
    assign lastBeat   = (elemIdxExt + LANES_EXT) >= vl;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values; blocking here would create order-dependent races.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so every path drives stateNext and no latch is inferred.
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    stateNext = (vlClamped != '0) ? RUN : COMMIT;
                end
            end
            RUN: begin
                if (Abort) begin
                    stateNext = IDLE;
                end else if (lastBeat) begin
                    stateNext = COMMIT;
                end
            end
            COMMIT: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Op context: destination, clamped length and beat index. ElemIdx holds on
    // the final beat so it still shows the last base index during COMMIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            WA3V    <= '0;
            vl      <= '0;
            ElemIdx <= '0;
        end else if (accept) begin
            WA3V    <= WA3D;
            vl      <= vlClamped;
            ElemIdx <= '0;
        end else if ((state == RUN) && !Abort && !lastBeat) begin
            ElemIdx <= ElemIdx + LANES_IDX;
        end
    end

    // Output decode from state.
    always_comb begin
        Busy      = 1'b0;
        BeatValid = 1'b0;
        RegWriteV = 1'b0;
        Done      = 1'b0;
        LaneEn    = '0;
        unique case (state)
            RUN: begin
                Busy      = 1'b1;
                BeatValid = 1'b1;
                for (int i = 0; i < LANES; i++) begin
                    LaneEn[i] = (elemIdxExt + (IDX_W+1)'(i)) < vl;
                end
            end
            COMMIT: begin
                Busy      = 1'b1;
                // A flush in the commit cycle must not reach the register file.
                RegWriteV = !Abort;
                Done      = !Abort;
            end
            default: begin
            end
        endcase
    end

    assign StallVec = Busy & (IssueD | (RA1D == WA3V) | (RA2D == WA3V));

endmodule

// File: tb/tb_vec_issue_sequencer.sv
// Directed self-checking bench for vec_issue_sequencer (NUM_ELEMS=16, LANES=4).
module tb_vec_issue_sequencer;

    localparam int NUM_ELEMS = 16;
    localparam int LANES     = 4;
    localparam int ADDR_W    = 4;
    localparam int IDX_W     = $clog2(NUM_ELEMS);

    logic              clk;
    logic              reset;
    logic              IssueD;
    logic [ADDR_W-1:0] WA3D;
    logic [IDX_W:0]    VLD;
    logic [ADDR_W-1:0] RA1D;
    logic [ADDR_W-1:0] RA2D;
    logic              Abort;
    logic              Busy;
    logic              StallVec;
    logic              BeatValid;
    logic [IDX_W-1:0]  ElemIdx;
    logic [LANES-1:0]  LaneEn;
    logic [ADDR_W-1:0] WA3V;
    logic              RegWriteV;
    logic              Done;

    int testsRun;
    int testsFailed;

    vec_issue_sequencer #(
        .NUM_ELEMS(NUM_ELEMS),
        .LANES(LANES),
        .ADDR_W(ADDR_W),
        .IDX_W(IDX_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .IssueD(IssueD),
        .WA3D(WA3D),
        .VLD(VLD),
        .RA1D(RA1D),
        .RA2D(RA2D),
        .Abort(Abort),
        .Busy(Busy),
        .StallVec(StallVec),
        .BeatValid(BeatValid),
        .ElemIdx(ElemIdx),
        .LaneEn(LaneEn),
        .WA3V(WA3V),
        .RegWriteV(RegWriteV),
        .Done(Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue an op and walk it to completion, checking every beat and the commit.
    task automatic runOp(input logic [ADDR_W-1:0] wa, input logic [IDX_W:0] vlen,
                         input int nBeats, input logic [LANES-1:0] lastLanes);
        IssueD = 1'b1;
        WA3D   = wa;
        VLD    = vlen;
        tick();
        IssueD = 1'b0;
        for (int b = 0; b < nBeats; b++) begin
            check($sformatf("beat%0d BeatValid", b), 32'(BeatValid), 32'd1);
            check($sformatf("beat%0d ElemIdx", b), 32'(ElemIdx), 32'(b * LANES));
            check($sformatf("beat%0d LaneEn", b), 32'(LaneEn),
                  (b == nBeats - 1) ? 32'(lastLanes) : 32'hF);
            check($sformatf("beat%0d RegWriteV", b), 32'(RegWriteV), 32'd0);
            check($sformatf("beat%0d WA3V", b), 32'(WA3V), 32'(wa));
            tick();
        end
        check("commit RegWriteV", 32'(RegWriteV), 32'd1);
        check("commit Done", 32'(Done), 32'd1);
        check("commit BeatValid", 32'(BeatValid), 32'd0);
        check("commit LaneEn", 32'(LaneEn), 32'd0);
        check("commit Busy", 32'(Busy), 32'd1);
        check("commit ElemIdx", 32'(ElemIdx), (nBeats == 0) ? 32'd0 : 32'((nBeats - 1) * LANES));
        tick();
        check("post Busy", 32'(Busy), 32'd0);
        check("post RegWriteV", 32'(RegWriteV), 32'd0);
        check("post Done", 32'(Done), 32'd0);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset  = 1'b1;
        IssueD = 1'b0;
        WA3D   = '0;
        VLD    = '0;
        RA1D   = 4'd2;
        RA2D   = 4'd2;
        Abort  = 1'b0;

        #12;
        check("rst Busy", 32'(Busy), 32'd0);
        check("rst StallVec", 32'(StallVec), 32'd0);
        check("rst BeatValid", 32'(BeatValid), 32'd0);
        check("rst LaneEn", 32'(LaneEn), 32'd0);
        check("rst ElemIdx", 32'(ElemIdx), 32'd0);
        check("rst WA3V", 32'(WA3V), 32'd0);
        check("rst RegWriteV", 32'(RegWriteV), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Full length, partial last beat, zero length, over-length clamp.
        runOp(4'd3, 5'd16, 4, 4'b1111);
        runOp(4'd4, 5'd10, 3, 4'b0011);
        runOp(4'd1, 5'd0, 0, 4'b0000);
        runOp(4'd8, 5'd20, 4, 4'b1111);
        runOp(4'd11, 5'd7, 2, 4'b0111);

        // Issue with simultaneous abort is dropped.
        IssueD = 1'b1;
        Abort  = 1'b1;
        WA3D   = 4'd12;
        VLD    = 5'd8;
        tick();
        IssueD = 1'b0;
        Abort  = 1'b0;
        check("issue+abort Busy", 32'(Busy), 32'd0);

        // Hazards while busy on register 5.
        IssueD = 1'b1;
        WA3D   = 4'd5;
        VLD    = 5'd16;
        tick();
        IssueD = 1'b0;
        RA1D   = 4'd2;
        RA2D   = 4'd2;
        #1;
        check("haz none StallVec", 32'(StallVec), 32'd0);
        RA1D = 4'd5;
        #1;
        check("haz RA1 StallVec", 32'(StallVec), 32'd1);
        RA1D = 4'd2;
        RA2D = 4'd5;
        #1;
        check("haz RA2 StallVec", 32'(StallVec), 32'd1);
        RA2D   = 4'd2;
        IssueD = 1'b1;
        WA3D   = 4'd7;
        VLD    = 5'd4;
        #1;
        check("haz issue StallVec", 32'(StallVec), 32'd1);
        for (int b = 1; b < 4; b++) begin
            tick();
            check($sformatf("haz beat%0d ElemIdx", b), 32'(ElemIdx), 32'(b * LANES));
            check($sformatf("haz beat%0d WA3V", b), 32'(WA3V), 32'd5);
            check($sformatf("haz beat%0d StallVec", b), 32'(StallVec), 32'd1);
        end
        tick();
        check("haz commit RegWriteV", 32'(RegWriteV), 32'd1);
        check("haz commit StallVec", 32'(StallVec), 32'd1);
        check("haz commit WA3V", 32'(WA3V), 32'd5);
        tick();
        check("haz idle Busy", 32'(Busy), 32'd0);
        check("haz idle StallVec", 32'(StallVec), 32'd0);
        tick();
        IssueD = 1'b0;
        check("haz accept Busy", 32'(Busy), 32'd1);
        check("haz accept WA3V", 32'(WA3V), 32'd7);
        check("haz accept LaneEn", 32'(LaneEn), 32'hF);
        tick();
        check("haz accept commit", 32'(RegWriteV), 32'd1);
        tick();
        check("haz accept idle", 32'(Busy), 32'd0);

        // Abort on the second beat.
        IssueD = 1'b1;
        WA3D   = 4'd9;
        VLD    = 5'd16;
        tick();
        IssueD = 1'b0;
        tick();
        check("abort beat ElemIdx", 32'(ElemIdx), 32'd4);
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        check("abort Busy", 32'(Busy), 32'd0);
        check("abort BeatValid", 32'(BeatValid), 32'd0);
        check("abort RegWriteV", 32'(RegWriteV), 32'd0);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("abort quiet%0d RegWriteV", c), 32'(RegWriteV), 32'd0);
            tick();
        end
        runOp(4'd2, 5'd8, 2, 4'b1111);

        // Abort during the commit cycle suppresses the pulse.
        IssueD = 1'b1;
        WA3D   = 4'd10;
        VLD    = 5'd4;
        tick();
        IssueD = 1'b0;
        tick();
        check("abortC pre RegWriteV", 32'(RegWriteV), 32'd1);
        Abort = 1'b1;
        #1;
        check("abortC RegWriteV", 32'(RegWriteV), 32'd0);
        check("abortC Done", 32'(Done), 32'd0);
        tick();
        Abort = 1'b0;
        check("abortC Busy", 32'(Busy), 32'd0);

        // Asynchronous reset mid-RUN.
        IssueD = 1'b1;
        WA3D   = 4'd6;
        VLD    = 5'd16;
        RA1D   = 4'd0;
        tick();
        IssueD = 1'b0;
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("areset Busy", 32'(Busy), 32'd0);
        check("areset BeatValid", 32'(BeatValid), 32'd0);
        check("areset LaneEn", 32'(LaneEn), 32'd0);
        check("areset ElemIdx", 32'(ElemIdx), 32'd0);
        check("areset WA3V", 32'(WA3V), 32'd0);
        check("areset StallVec", 32'(StallVec), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        RA1D  = 4'd2;
        tick();
        runOp(4'd13, 5'd4, 1, 4'b1111);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
